nasti_stream_fifo: RTL and testbench

- Buffers one NASTI stream downstream of the stream mux's output port.
- Stores every beat with all sideband fields (data, strb, keep, last, id, dest, user).
- Decouples the mux from a slow consumer (DMA or peripheral sink), so the mux releases its latched port as soon as `t_last` is accepted, not when the consumer drains it.
- An optional packet mode holds output beats until a whole packet is buffered.

---
 rtl/nasti_stream_fifo_if.sv | 29 ++
 rtl/nasti_stream_fifo.sv | 128 ++++++++++++
 tb/tb_nasti_stream_fifo.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_stream_fifo_if.sv
// NASTI stream channel: valid/ready stream with AXI-Stream style sidebands.
// Every signal is a vector over N_PORT ports.
interface nasti_stream_channel #(
    parameter int N_PORT     = 1,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [N_PORT-1:0]                   t_valid;
    logic [N_PORT-1:0]                   t_ready;
    logic [N_PORT-1:0][DATA_WIDTH-1:0]   t_data;
    logic [N_PORT-1:0][DATA_WIDTH/8-1:0] t_strb;
    logic [N_PORT-1:0][DATA_WIDTH/8-1:0] t_keep;
    logic [N_PORT-1:0]                   t_last;
    logic [N_PORT-1:0][ID_WIDTH-1:0]     t_id;
    logic [N_PORT-1:0][DEST_WIDTH-1:0]   t_dest;
    logic [N_PORT-1:0][USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_fifo.sv
// Single-clock NASTI stream FIFO between the stream mux and a slow sink.
// Define NASTI_STREAM_FIFO_PKT_MODE_EN for store-and-forward packet mode.
module nasti_stream_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    nasti_stream_channel.slave   in,
    nasti_stream_channel.master  out,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 full,
    output logic                 empty
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
        logic [STRB_W-1:0]     keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               wr_entry;
    entry_t               rd_entry;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic                 push, pop;
    logic                 out_valid;

    assign full      = (count_q == CNT_WIDTH'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign pkt_count = pkt_q;

    assign in.t_ready[0] = ~full;
    assign push          = in.t_valid[0] & ~full;
    assign pop           = out_valid & out.t_ready[0];

    assign wr_entry = '{
        data: in.t_data[0],
        strb: in.t_strb[0],
        keep: in.t_keep[0],
        last: in.t_last[0],
        id:   in.t_id[0],
        dest: in.t_dest[0],
        user: in.t_user[0]
    };

    assign rd_entry = mem_q[rptr_q];

    assign out.t_valid[0] = out_valid;
    assign out.t_data[0]  = rd_entry.data;
    assign out.t_strb[0]  = rd_entry.strb;
    assign out.t_keep[0]  = rd_entry.keep;
    assign out.t_last[0]  = rd_entry.last;
    assign out.t_id[0]    = rd_entry.id;
    assign out.t_dest[0]  = rd_entry.dest;
    assign out.t_user[0]  = rd_entry.user;

`ifdef NASTI_STREAM_FIFO_PKT_MODE_EN
    logic draining_q, draining_d;

    // A packet started by the full fallback keeps flowing until its last beat.
    always_comb begin
        draining_d = draining_q;
        if (pop) begin
            if (rd_entry.last) begin
                draining_d = 1'b0;
            end else if (full && pkt_q == '0) begin
                draining_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            draining_q <= 1'b0;
        end else begin
            draining_q <= draining_d;
        end
    end

    assign out_valid = ~empty & ((pkt_q != '0) | full | draining_q);
`else
    assign out_valid = ~empty;
`endif

    always_comb begin
        wptr_d  = wptr_q + PTR_W'(push);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        pkt_d   = pkt_q + CNT_WIDTH'(push & in.t_last[0])
                        - CNT_WIDTH'(pop & rd_entry.last);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            pkt_q   <= pkt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_nasti_stream_fifo.sv
// Scoreboard bench for nasti_stream_fifo: queue reference model, random traffic.
// Packet-mode checks are compiled when NASTI_STREAM_FIFO_PKT_MODE_EN is defined.
module tb_nasti_stream_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic        id;
        logic        dest;
        logic        user;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic [CW-1:0] count, pkt_count;
    logic          full, empty;

    nasti_stream_channel #(.N_PORT(1), .DATA_WIDTH(DW)) in_if ();
    nasti_stream_channel #(.N_PORT(1), .DATA_WIDTH(DW)) out_if ();

    nasti_stream_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in        (in_if),
        .out       (out_if),
        .count     (count),
        .pkt_count (pkt_count),
        .full      (full),
        .empty     (empty)
    );

    always #5 aclk = ~aclk;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    npop = 0;
    bit    chk_en = 0;
    bit    drn = 0;
    int    n_size = 0;
    int    n_lasts = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sb_lasts();
        int n = 0;
        foreach (sb[i]) if (sb[i].last) n++;
        return n;
    endfunction

    function automatic bit exp_valid(input int sz, input int nl);
`ifdef NASTI_STREAM_FIFO_PKT_MODE_EN
        return sz != 0 && (nl != 0 || sz == DEPTH || drn);
`else
        return sz != 0;
`endif
    endfunction

    // Input monitor: every accepted beat becomes an expected output.
    always @(posedge aclk) begin
        if (aresetn && in_if.t_valid[0] === 1'b1 && in_if.t_ready[0] === 1'b1) begin
            beat_t b;
            b.data = in_if.t_data[0];
            b.strb = in_if.t_strb[0];
            b.keep = in_if.t_keep[0];
            b.last = in_if.t_last[0];
            b.id   = in_if.t_id[0];
            b.dest = in_if.t_dest[0];
            b.user = in_if.t_user[0];
            sb.push_back(b);
        end
    end

    // Output monitor: pop the oldest expected beat on each accepted output.
    always @(posedge aclk) begin
        if (aresetn && out_if.t_valid[0] === 1'b1 && out_if.t_ready[0] === 1'b1) begin
            beat_t e;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_if.t_data[0], e.data);
                chk("out_strb", 64'(out_if.t_strb[0]), 64'(e.strb));
                chk("out_keep", 64'(out_if.t_keep[0]), 64'(e.keep));
                chk("out_last", 64'(out_if.t_last[0]), 64'(e.last));
                chk("out_id", 64'(out_if.t_id[0]), 64'(e.id));
                chk("out_dest", 64'(out_if.t_dest[0]), 64'(e.dest));
                chk("out_user", 64'(out_if.t_user[0]), 64'(e.user));
                if (e.last) drn = 0;
                else if (n_size == DEPTH && n_lasts == 0) drn = 1;
            end
            npop++;
        end
    end

    // State checks against the model, mid-cycle.
    always @(negedge aclk) begin
        n_size  = sb.size();
        n_lasts = sb_lasts();
        if (chk_en) begin
            chk("count", 64'(count), 64'(n_size));
            chk("pkt_count", 64'(pkt_count), 64'(n_lasts));
            chk("full", 64'(full), 64'(n_size == DEPTH));
            chk("empty", 64'(empty), 64'(n_size == 0));
            chk("in_ready", 64'(in_if.t_ready[0]), 64'(n_size != DEPTH));
            chk("out_valid", 64'(out_if.t_valid[0]), 64'(exp_valid(n_size, n_lasts)));
        end
    end

    function automatic beat_t mk(input logic [63:0] d, input bit last);
        beat_t b;
        b.data = d;
        b.strb = 8'($urandom);
        b.keep = 8'($urandom);
        b.last = last;
        b.id   = 1'($urandom);
        b.dest = 1'($urandom);
        b.user = 1'($urandom);
        return b;
    endfunction

    task automatic put(input beat_t b);
        in_if.t_data[0]  = b.data;
        in_if.t_strb[0]  = b.strb;
        in_if.t_keep[0]  = b.keep;
        in_if.t_last[0]  = b.last;
        in_if.t_id[0]    = b.id;
        in_if.t_dest[0]  = b.dest;
        in_if.t_user[0]  = b.user;
        in_if.t_valid[0] = 1'b1;
    endtask

    task automatic send(input beat_t b);
        bit acc;
        int n = 0;
        put(b);
        do begin
            @(negedge aclk);
            acc = in_if.t_ready[0];
            @(posedge aclk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_if.t_valid[0] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_if.t_ready[0] = 1'b1;
        while (sb.size() != 0 && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
        out_if.t_ready[0] = 1'b0;
    endtask

    bit rnd_done;

    initial begin
        int base;
        in_if.t_valid[0]  = 1'b0;
        out_if.t_ready[0] = 1'b0;
        put(mk(64'd0, 1'b0));
        in_if.t_valid[0]  = 1'b0;

        #2 aresetn = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_in_ready", 64'(in_if.t_ready[0]), 64'd1);
        chk("rst_out_valid", 64'(out_if.t_valid[0]), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        chk_en = 1;
        @(posedge aclk);
        #1;

        // Single beat
        begin
            beat_t b = mk(64'hA5, 1'b1);
            b.id = 1'b1;
            send(b);
        end
        chk("one_valid", 64'(out_if.t_valid[0]), 64'd1);
        chk("one_data", out_if.t_data[0], 64'hA5);
        chk("one_id", 64'(out_if.t_id[0]), 64'd1);
        chk("one_pkt", 64'(pkt_count), 64'd1);
        drain();

        // Fill to full with sink stalled
        for (int i = 0; i < DEPTH; i++) send(mk(64'(i), 1'b1));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(in_if.t_ready[0]), 64'd0);
        put(mk(64'd16, 1'b1));
        repeat (3) @(posedge aclk);
        #1;
        chk("held_count", 64'(count), 64'(DEPTH));
        out_if.t_ready[0] = 1'b1;
        @(posedge aclk);
        #1;
        out_if.t_ready[0] = 1'b0;
        chk("pop_ready", 64'(in_if.t_ready[0]), 64'd1);
        chk("pop_count", 64'(count), 64'(DEPTH - 1));
        @(posedge aclk);
        #1;
        in_if.t_valid[0] = 1'b0;
        chk("refill_count", 64'(count), 64'(DEPTH));
        drain();

        // Continuous streaming
        out_if.t_ready[0] = 1'b1;
        base = npop;
        for (int i = 0; i < 40; i++) begin
            put(mk(64'(100 + i), 1'b1));
            @(posedge aclk);
            #1;
            chk("stream_count", 64'(count), 64'd1);
        end
        in_if.t_valid[0] = 1'b0;
        @(posedge aclk);
        #1;
        chk("stream_pops", 64'(npop - base), 64'd40);
        out_if.t_ready[0] = 1'b0;

        // Random traffic and backpressure
        rnd_done = 0;
        fork
            begin
                int nb = 0;
                while (nb < 1000) begin
                    int len = $urandom_range(1, 8);
                    for (int i = 0; i < len; i++) begin
                        in_if.t_valid[0] = 1'b0;
                        repeat ($urandom_range(0, 2)) @(posedge aclk);
                        #1;
                        send(mk({$urandom, $urandom}, i == len - 1));
                        nb++;
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge aclk);
                    #1;
                    out_if.t_ready[0] = ($urandom_range(0, 9) < 7);
                end
            end
        join
        drain();

`ifdef NASTI_STREAM_FIFO_PKT_MODE_EN
        // Store-and-forward: held until the last beat lands
        out_if.t_ready[0] = 1'b1;
        base = npop;
        for (int i = 0; i < 4; i++) begin
            send(mk(64'(200 + i), i == 3));
            chk("pkt_hold", 64'(out_if.t_valid[0]), 64'(i == 3));
        end
        repeat (4) @(posedge aclk);
        #1;
        chk("pkt4_pops", 64'(npop - base), 64'd4);
        base = npop;
        for (int i = 0; i < 20; i++) send(mk(64'(300 + i), i == 19));
        drain();
        chk("pkt20_pops", 64'(npop - base), 64'd20);
`endif

        // Asynchronous reset mid-packet
        out_if.t_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(64'(400 + i), 1'b0));
        chk("mid_count", 64'(count), 64'd5);
        #2;
        aresetn = 1'b0;
        sb.delete();
        drn = 0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_if.t_valid[0]), 64'd0);
        chk("arst_in_ready", 64'(in_if.t_ready[0]), 64'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        base = npop;
        for (int i = 0; i < 3; i++) send(mk(64'(500 + i), i == 2));
        drain();
        chk("post_rst_pops", 64'(npop - base), 64'd3);

        repeat (2) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
